// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt scheduler between the MEM stage and CP0.
// Picks the highest-priority exception of the MEM-stage instruction (or a
// masked hardware interrupt), commits it to CP0 for one cycle, then holds a
// pipeline flush with a PC redirect for FLUSH_CYCLES cycles in total.
// Optional feature: define EXC_CTRL_COUNT_EN to add exc_count_o, a saturating
// count of committed non-eret exceptions.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_slot_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delay_slot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_req_o,
  output logic        busy_o
`ifdef EXC_CTRL_COUNT_EN
  ,
  output logic [15:0] exc_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

  localparam logic [4:0] CODE_NONE    = 5'h00;
  localparam logic [4:0] CODE_INT     = 5'h01;
  localparam logic [4:0] CODE_SYSCALL = 5'h08;
  localparam logic [4:0] CODE_INVALID = 5'h0a;
  localparam logic [4:0] CODE_OVF     = 5'h0c;
  localparam logic [4:0] CODE_TRAP    = 5'h0d;
  localparam logic [4:0] CODE_ERET    = 5'h0e;

  // Remaining FLUSH cycles after COMMIT; a zero load means COMMIT is the only flush cycle.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        stall_hold;
  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pending;
  logic [4:0]  code;
  logic        candidate;

  // Forward an in-flight WB mtc0 so decisions see the CP0 values about to be written.
  always_comb begin
    eff_status = status_i;
    eff_cause  = cause_i;
    eff_epc    = epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12:   eff_status = wb_cp0_data_i;
        5'd13:   eff_cause[9:8] = wb_cp0_data_i[9:8];
        5'd14:   eff_epc = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  // Pick the single highest-priority exception code; lower-priority flags are dropped.
  always_comb begin
    int_pending = (|(eff_cause[15:8] & eff_status[15:8])) && eff_status[0] && !eff_status[1];
    code = CODE_NONE;
    if (int_pending)       code = CODE_INT;
    else if (mem_exc_i[4]) code = CODE_SYSCALL;
    else if (mem_exc_i[3]) code = CODE_INVALID;
    else if (mem_exc_i[2]) code = CODE_TRAP;
    else if (mem_exc_i[1]) code = CODE_OVF;
    else if (mem_exc_i[0]) code = CODE_ERET;
    candidate = mem_valid_i && (state == IDLE) && (code != CODE_NONE);
  end

  // Stall the front of the pipe the moment a candidate appears, and while sequencing.
  assign stall_req_o = stall_hold | candidate;

  // Sequencer: capture the winner, commit it for one cycle, then hold the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= 3'd0;
      excepttype_o        <= 32'd0;
      current_inst_addr_o <= 32'd0;
      is_in_delay_slot_o  <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'd0;
      stall_hold          <= 1'b0;
      busy_o              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (candidate) begin
            state               <= COMMIT;
            excepttype_o        <= {27'd0, code};
            current_inst_addr_o <= mem_pc_i;
            is_in_delay_slot_o  <= mem_in_delay_slot_i;
            flush_o             <= 1'b1;
            new_pc_o            <= (code == CODE_ERET) ? eff_epc : EXC_VECTOR;
            stall_hold          <= 1'b1;
            busy_o              <= 1'b1;
          end
        end
        COMMIT: begin
          cnt                 <= CNT_LOAD;
          excepttype_o        <= 32'd0;
          current_inst_addr_o <= 32'd0;
          is_in_delay_slot_o  <= 1'b0;
          if (CNT_LOAD != 3'd0) begin
            state <= FLUSH;
          end else begin
            state      <= IDLE;
            flush_o    <= 1'b0;
            new_pc_o   <= 32'd0;
            stall_hold <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state      <= IDLE;
            flush_o    <= 1'b0;
            new_pc_o   <= 32'd0;
            stall_hold <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXC_CTRL_COUNT_EN
  // Saturating tally of committed exceptions, eret excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_o <= 16'd0;
    end else if (state == COMMIT && excepttype_o != {27'd0, CODE_ERET} && exc_count_o != 16'hFFFF) begin
      exc_count_o <= exc_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt scheduler between the MEM stage and the CP0 register file.
- Each cycle it arbitrates among pending exception flags of the MEM-stage instruction and masked hardware interrupts.
- For the winner it sequences a one-cycle CP0 commit (excepttype/EPC/delay-slot), then a pipeline flush and a PC redirect.
- Forwards in-flight WB-stage mtc0 writes so decisions use current Status/Cause/EPC.

Parameters:
EXC_VECTOR, 32'h80000180, redirect PC for all non-eret exceptions
FLUSH_CYCLES, 2, total cycles flush_o held (COMMIT plus FLUSH states), legal range 1..7

Ports:
clk  in  1  clock
rst  in  1  reset
mem_valid_i  in  1  MEM-stage instruction valid
mem_pc_i  in  32  MEM-stage instruction address
mem_in_delay_slot_i  in  1  MEM instruction is in a delay slot
mem_exc_i  in  5  {syscall, invalid_inst, trap, overflow, eret}
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause
epc_i  in  32  CP0 EPC
wb_cp0_we_i  in  1  WB-stage mtc0 write enable
wb_cp0_waddr_i  in  5  WB mtc0 register address
wb_cp0_data_i  in  32  WB mtc0 data
excepttype_o  out  32  exception code to CP0 (0 = none)
current_inst_addr_o  out  32  faulting PC to CP0
is_in_delay_slot_o  out  1  delay-slot flag to CP0
flush_o  out  1  pipeline flush
new_pc_o  out  32  redirect target, valid while flush_o=1
stall_req_o  out  1  hold IF..MEM
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk, all state on posedge clk.
- Reset values: excepttype_o=0, current_inst_addr_o=0, is_in_delay_slot_o=0, flush_o=0, new_pc_o=0, stall_req_o=0, busy_o=0; FSM=IDLE, flush counter=0.
- Forwarding (combinational):
  - Effective Status/EPC = wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i=12 (Status) or 14 (EPC).
  - Effective Cause[9:8] = wb_cp0_data_i[9:8] when waddr=13; otherwise the register input.
- Interrupt pending = |(Cause[15:8] & Status[15:8]) && Status[0]==1 && Status[1]==0.
- Candidate only when mem_valid_i=1 and FSM=IDLE.
- Priority, highest first:
  - interrupt 0x1
  - syscall 0x8
  - invalid_inst 0xa
  - trap 0xd
  - overflow 0xc
  - eret 0xe
  - Multiple flags set: only the highest is taken; the rest are dropped.
- FSM states:
  - IDLE:
    - Candidate exists: stall_req_o=1 combinationally in the same cycle.
    - Latch code, mem_pc_i, mem_in_delay_slot_i.
    - Compute target: eret -> effective EPC; others -> EXC_VECTOR.
    - Go to COMMIT.
  - COMMIT (exactly 1 cycle):
    - excepttype_o, current_inst_addr_o, is_in_delay_slot_o = latched values.
    - flush_o=1, new_pc_o=target, stall_req_o=1, busy_o=1.
    - Load counter with FLUSH_CYCLES-1. Go to FLUSH if counter >0, else IDLE.
  - FLUSH:
    - excepttype_o=0; flush_o=1, new_pc_o=target, stall_req_o=1, busy_o=1.
    - Decrement counter; at 0 go to IDLE on the next edge.
- Latency: detection in cycle N -> excepttype_o nonzero in N+1 only; flush_o high N+1..N+FLUSH_CYCLES.
- First new candidate is accepted at N+FLUSH_CYCLES+1.
- excepttype_o is never nonzero for two consecutive cycles.
- Inputs during COMMIT/FLUSH are ignored; flagged instructions there are flushed and never reported.
- mem_valid_i=0: no candidate, even if an interrupt is pending; the interrupt waits for a valid instruction.
- rst during COMMIT/FLUSH: returns to IDLE next edge, all outputs at reset values, no partial commit.
- Address arithmetic: none beyond muxing; 32-bit values pass unmodified.

Optional Feature:
- Macro: EXC_CTRL_COUNT_EN.
- Defined:
  - Adds output exc_count_o [15:0]: saturating count of COMMIT cycles with code ≠ 0xe (eret not counted).
  - Reset 0; holds at 16'hFFFF.
- Undefined: port absent, no counter logic.

Test Plan:
- syscall at PC 0x00000100, not in delay slot:
  - N+1: excepttype_o=0x8, current_inst_addr_o=0x100, flush_o=1, new_pc_o=0x80000180.
  - N+2: flush_o=1, excepttype_o=0. N+3: busy_o=0.
- Cause[10]=1, Status=0x00000401, mem_valid_i=1, overflow flag also set -> excepttype_o=0x1 only; overflow dropped.
- Same interrupt with Status[1]=1, or with WB mtc0 to Status writing 0x0 in the same cycle -> no exception, flush_o stays 0.
- eret with epc_i=0x200 and WB mtc0 to EPC writing 0x340 same cycle -> excepttype_o=0xe, new_pc_o=0x340.
- Back-to-back trap flags at N and N+1 with FLUSH_CYCLES=2:
  - Only the first commits.
  - Trap presented at N+3 commits at N+4 with code 0xd.
- rst asserted in COMMIT cycle -> next cycle all outputs 0, busy_o=0; with EXC_CTRL_COUNT_EN, exc_count_o=0.
